cp0_regs: RTL and testbench

- Coprocessor-0 register file and exception-state machine for the 5-stage MIPS core.
- Downstream of the ID-stage privileged decoder: consumes the mtc0/mfc0/eret classification once it reaches MEM, plus the exception vector collected in MEM.
- Supplies EPC and Status to the exception/flush unit, and supplies mfc0 read data.

---
 rtl/cp0_pkg.sv | 44 ++++
 rtl/cp0_timer.sv | 56 +++++
 rtl/cp0_regs.sv | 143 ++++++++++++++
 tb/tb_cp0_regs.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, write masks and bit positions.
package cp0_pkg;

    localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;
    localparam logic [4:0] CP0_ADDR_PRID     = 5'd15;
    localparam logic [4:0] CP0_ADDR_CONFIG   = 5'd16;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam int STATUS_EXL_BIT = 1;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_IP_HW_LO = 10;

    // True for the exception codes that enter the handler (eret is excluded).
    function automatic logic is_exc_code(input logic [31:0] code);
        return (code == EXC_INT)  || (code == EXC_ADEL) || (code == EXC_ADES) ||
               (code == EXC_SYS)  || (code == EXC_BP)   || (code == EXC_RI)   ||
               (code == EXC_OV);
    endfunction

    function automatic logic [31:0] mask_write(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer. Define CP0_TIMER_INT_EN to build the Count==Compare interrupt.
import cp0_pkg::*;

module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] data,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        tick_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;

    // Count advances on every second cycle; a software write takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg    <= 1'b0;
            count_reg   <= 32'd0;
            compare_reg <= 32'd0;
        end else begin
            tick_reg <= ~tick_reg;
            if (we_count)
                count_reg <= data;
            else if (tick_reg)
                count_reg <= count_reg + 32'd1;
            if (we_compare)
                compare_reg <= data;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic timer_int_reg;

    always_ff @(posedge clk) begin
        if (rst)
            timer_int_reg <= 1'b0;
        else if (we_compare)
            timer_int_reg <= 1'b0;
        else if ((count_reg == compare_reg) && (compare_reg != 32'd0))
            timer_int_reg <= 1'b1;
    end

    assign timer_int_o = timer_int_reg;
`else
    assign timer_int_o = 1'b0;
`endif

    assign count_o   = count_reg;
    assign compare_o = compare_reg;

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file and exception-state update for the 5-stage MIPS core.
// Timer interrupt into IP7 is built only when CP0_TIMER_INT_EN is defined.
import cp0_pkg::*;

module cp0_regs #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_0000,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    logic [31:0] status_reg, status_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] status_wr_val, cause_wr_val;
    logic [5:0]  ip_hw;
    logic        timer_int;
    logic        exc_take, exc_eret;

    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_count    (we_i && (waddr_i == CP0_ADDR_COUNT)),
        .we_compare  (we_i && (waddr_i == CP0_ADDR_COMPARE)),
        .data        (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int)
    );

    // Hardware-driven pending bits; the timer shares IP7 with int_i[5].
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ip_hw
            if (gi == 5) begin : g_ip7
                assign ip_hw[gi] = int_i[gi] | timer_int;
            end else begin : g_ipn
                assign ip_hw[gi] = int_i[gi];
            end
        end
    endgenerate

    assign exc_take      = is_exc_code(excepttype_i);
    assign exc_eret      = (excepttype_i == EXC_ERET);
    assign status_wr_val = mask_write(status_reg, data_i, STATUS_WMASK);
    assign cause_wr_val  = mask_write(cause_reg, data_i, CAUSE_WMASK);

    // mtc0 is applied first; exception/eret fields then override it.
    always_comb begin
        status_next   = status_reg;
        cause_next    = cause_reg;
        epc_next      = epc_reg;
        badvaddr_next = badvaddr_reg;

        if (we_i && (waddr_i == CP0_ADDR_STATUS))
            status_next = status_wr_val;
        if (we_i && (waddr_i == CP0_ADDR_CAUSE))
            cause_next = cause_wr_val;
        if (we_i && (waddr_i == CP0_ADDR_EPC))
            epc_next = data_i;
        cause_next[CAUSE_IP_HW_LO +: 6] = ip_hw;

        if (exc_take) begin
            if (!status_reg[STATUS_EXL_BIT]) begin
                epc_next                 = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_next[CAUSE_BD_BIT] = in_delayslot_i;
            end
            status_next[STATUS_EXL_BIT] = 1'b1;
            cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO] =
                (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];
            if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES))
                badvaddr_next = bad_addr_i;
        end else if (exc_eret) begin
            status_next[STATUS_EXL_BIT] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg   <= STATUS_RST;
            cause_reg    <= 32'd0;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
        end else begin
            status_reg   <= status_next;
            cause_reg    <= cause_next;
            epc_reg      <= epc_next;
            badvaddr_reg <= badvaddr_next;
        end
    end

    // mfc0 read port, forwarding a same-cycle mtc0 to a writable register.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_ADDR_BADVADDR: data_o = badvaddr_reg;
            CP0_ADDR_COUNT:    data_o = count_o;
            CP0_ADDR_COMPARE:  data_o = compare_o;
            CP0_ADDR_STATUS:   data_o = status_reg;
            CP0_ADDR_CAUSE:    data_o = cause_reg;
            CP0_ADDR_EPC:      data_o = epc_reg;
            CP0_ADDR_PRID:     data_o = PRID_VAL;
            CP0_ADDR_CONFIG:   data_o = CONFIG_VAL;
            default:           data_o = 32'd0;
        endcase
        if (we_i && (waddr_i == raddr_i)) begin
            case (waddr_i)
                CP0_ADDR_COUNT,
                CP0_ADDR_COMPARE,
                CP0_ADDR_EPC:     data_o = data_i;
                CP0_ADDR_STATUS:  data_o = status_wr_val;
                CP0_ADDR_CAUSE:   data_o = cause_wr_val;
                default:          ;
            endcase
        end
    end

    assign status_o    = status_reg;
    assign cause_o     = cause_reg;
    assign epc_o       = epc_reg;
    assign badvaddr_o  = badvaddr_reg;
    assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed self-checking bench for cp0_regs; timer expectations follow CP0_TIMER_INT_EN.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;

    int total = 0;
    int bad   = 0;

`ifdef CP0_TIMER_INT_EN
    localparam logic TIMER_ON = 1'b1;
`else
    localparam logic TIMER_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    cp0_regs dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .raddr_i        (raddr_i),
        .data_i         (data_i),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_addr_i     (bad_addr_i),
        .data_o         (data_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .badvaddr_o     (badvaddr_o),
        .timer_int_o    (timer_int_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        $display("txn mtc0 addr=%0d data=%h", a, d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                       input logic [31:0] ba);
        $display("txn exception code=%h pc=%h ds=%0b bad=%h", code, pc, ds, ba);
        excepttype_i = code; pc_i = pc; in_delayslot_i = ds; bad_addr_i = ba;
        step();
        excepttype_i = 32'd0; in_delayslot_i = 1'b0;
    endtask

    initial begin
        int waited;
        rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; data_i = 32'd0;
        int_i = 6'd0; excepttype_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0;
        bad_addr_i = 32'd0;

        $display("txn reset");
        step(); step();
        rst = 1'b0;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_badvaddr", badvaddr_o, 32'd0);
        check("rst_count", count_o, 32'd0);
        check("rst_compare", compare_o, 32'd0);
        check("rst_timer", {31'd0, timer_int_o}, 32'd0);
        raddr_i = 5'd15; #1;
        check("read_prid", data_o, 32'h0000_4220);
        raddr_i = 5'd20; #1;
        check("read_unmapped", data_o, 32'd0);
        step(); step();
        check("count_first_inc", count_o, 32'd1);

        // Status write mask and same-cycle forwarding
        $display("txn mtc0 status all-ones with forwarding");
        raddr_i = 5'd12; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF; #1;
        check("status_fwd", data_o, 32'h0040_FF03);
        step(); we_i = 1'b0;
        check("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'd0);
        check("status_clear", status_o, 32'h0040_0000);

        // Delay-slot syscall then eret
        exc(32'h8, 32'hBFC0_0104, 1'b1, 32'd0);
        check("sys_epc", epc_o, 32'hBFC0_0100);
        check("sys_cause", cause_o, 32'h8000_0020);
        check("sys_status", status_o, 32'h0040_0002);
        exc(32'hE, 32'h0, 1'b0, 32'd0);
        check("eret_status", status_o, 32'h0040_0000);
        check("eret_epc", epc_o, 32'hBFC0_0100);
        raddr_i = 5'd14; #1;
        check("read_epc", data_o, 32'hBFC0_0100);

        // Nested exception: break sets EXL, then AdEL must leave EPC/BD alone
        exc(32'h9, 32'h0000_0100, 1'b0, 32'd0);
        check("bp_epc", epc_o, 32'h0000_0100);
        check("bp_cause", cause_o, 32'h0000_0024);
        exc(32'h4, 32'h0000_0200, 1'b1, 32'h8000_0003);
        check("adel_epc", epc_o, 32'h0000_0100);
        check("adel_cause", cause_o, 32'h0000_0010);
        check("adel_badvaddr", badvaddr_o, 32'h8000_0003);
        check("adel_status", status_o, 32'h0040_0002);
        exc(32'hE, 32'h0, 1'b0, 32'd0);
        exc(32'h7, 32'h0000_0400, 1'b0, 32'h1234_5678);
        check("unrec_epc", epc_o, 32'h0000_0100);
        check("unrec_status", status_o, 32'h0040_0000);

        // Cause mask with forwarding, BadVAddr read-only, hardware IP sampling
        $display("txn mtc0 cause all-ones with forwarding");
        raddr_i = 5'd13; we_i = 1'b1; waddr_i = 5'd13; data_i = 32'hFFFF_FFFF; #1;
        check("cause_fwd", data_o, 32'h0000_0310);
        step(); we_i = 1'b0;
        check("cause_mask", cause_o, 32'h0000_0310);
        mtc0(5'd8, 32'hDEAD_BEEF);
        check("badvaddr_ro", badvaddr_o, 32'h8000_0003);
        $display("txn int_i=000011");
        int_i = 6'b000011; step();
        check("cause_ip_hw", cause_o, 32'h0000_0F10);
        int_i = 6'd0; step();
        check("cause_ip_clear", cause_o, 32'h0000_0310);

        // Timer
        mtc0(5'd9, 32'd3);
        mtc0(5'd11, 32'd5);
        check("compare_wr", compare_o, 32'd5);
        waited = 0;
        while (count_o != 32'd5 && waited < 20) begin
            step();
            waited++;
        end
        check("timer_reach_bound", {31'd0, (waited < 20)}, 32'd1);
        check("timer_pre", {31'd0, timer_int_o}, 32'd0);
        step();
        check("timer_set", {31'd0, timer_int_o}, {31'd0, TIMER_ON});
        step();
        check("cause_ip7", {31'd0, cause_o[15]}, {31'd0, TIMER_ON});
        check("timer_hold", {31'd0, timer_int_o}, {31'd0, TIMER_ON});
        mtc0(5'd11, 32'd20);
        check("timer_clr", {31'd0, timer_int_o}, 32'd0);
        check("compare_20", compare_o, 32'd20);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("count_load", count_o, 32'hFFFF_FFFF);
        step(); step();
        check("count_wrap", count_o, 32'd0);

        // Simultaneous mtc0 Status and Ov exception
        $display("txn mtc0 status=1 with Ov exception");
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000_0001;
        excepttype_i = 32'hC; pc_i = 32'h0000_0300; in_delayslot_i = 1'b0;
        step();
        we_i = 1'b0; excepttype_i = 32'd0;
        check("simul_status", status_o, 32'h0040_0003);
        check("simul_exccode", {27'd0, cause_o[6:2]}, 32'h0000_000C);
        check("simul_epc", epc_o, 32'h0000_0300);

        // Reset while an exception is presented
        $display("txn reset with pending syscall");
        rst = 1'b1; excepttype_i = 32'h8; pc_i = 32'h0000_0500;
        step();
        rst = 1'b0; excepttype_i = 32'd0;
        check("rst2_status", status_o, 32'h0040_0000);
        check("rst2_epc", epc_o, 32'd0);
        check("rst2_cause", cause_o, 32'd0);
        check("rst2_count", count_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
